rl_force_collector: RTL and testbench

RL_FORCE_COLLECTOR -- requirements
Module: rl_force_collector

---
 rtl/rl_force_collector.sv | 181 ++++++++++++++++++
 tb/tb_rl_force_collector.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rl_force_collector.sv
`default_nettype none
// rl_force_collector: merges CHANNEL_NUM pipeline force streams through 1-entry buffers and a
// round-robin arbiter into a single registered output. Optional counters: RL_COLLECTOR_STATS_EN.
module rl_force_collector #(
   parameter int DATA_WIDTH  = 32,
   parameter int CHANNEL_NUM = 8,
   parameter int CH_ID_WIDTH = 3,
   parameter int COUNT_WIDTH = 16
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              start,
   input  logic [CHANNEL_NUM*DATA_WIDTH-1:0] in_force,
   input  logic [CHANNEL_NUM-1:0]            in_valid,
   output logic [CHANNEL_NUM-1:0]            in_ready,
   input  logic [CHANNEL_NUM-1:0]            in_done,
   output logic [DATA_WIDTH-1:0]             out_force,
   output logic [CH_ID_WIDTH-1:0]            out_ch,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic                              busy,
   output logic                              done,
   output logic [COUNT_WIDTH-1:0]            result_count,
   output logic                              drop_err
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      DRAIN   = 2'd2,
      DONE    = 2'd3
   } state_t;

   state_t                   state_q, state_d;
   logic [CHANNEL_NUM-1:0]   buf_valid_q;
   logic [DATA_WIDTH-1:0]    buf_data_q [CHANNEL_NUM];
   logic [CHANNEL_NUM-1:0]   done_seen_q, done_seen_d;
   logic [CH_ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
   logic                     out_valid_q, out_valid_d;
   logic [DATA_WIDTH-1:0]    out_force_q, out_force_d;
   logic [CH_ID_WIDTH-1:0]   out_ch_q, out_ch_d;

   logic                     run_active, start_ok, out_load, grant_found;
   logic [CHANNEL_NUM-1:0]   accept, grant_oh;
   logic [CH_ID_WIDTH-1:0]   grant_id;
   logic [DATA_WIDTH-1:0]    grant_data;

   assign run_active = (state_q == COLLECT) || (state_q == DRAIN);
   assign start_ok   = start && ((state_q == IDLE) || (state_q == DONE));
   assign in_ready   = ~buf_valid_q & {CHANNEL_NUM{run_active}};
   assign accept     = in_valid & in_ready;
   assign out_load   = !out_valid_q || out_ready;

   // Outer loop walks offsets from the pointer so the nearest full buffer wins.
   always_comb begin
      grant_oh    = '0;
      grant_id    = '0;
      grant_found = 1'b0;
      if (out_load) begin
         for (int i = 0; i < CHANNEL_NUM; i++) begin
            for (int c = 0; c < CHANNEL_NUM; c++) begin
               if (!grant_found && buf_valid_q[c] &&
                   ((int'(rr_ptr_q) + i == c) || (int'(rr_ptr_q) + i == c + CHANNEL_NUM))) begin
                  grant_found = 1'b1;
                  grant_oh[c] = 1'b1;
                  grant_id    = CH_ID_WIDTH'(c);
               end
            end
         end
      end
   end

   always_comb begin
      grant_data = '0;
      for (int c = 0; c < CHANNEL_NUM; c++) begin
         if (grant_oh[c]) grant_data = grant_data | buf_data_q[c];
      end
   end

   always_comb begin
      state_d     = state_q;
      done_seen_d = done_seen_q;
      rr_ptr_d    = rr_ptr_q;
      out_valid_d = out_valid_q;
      out_force_d = out_force_q;
      out_ch_d    = out_ch_q;
      case (state_q)
         IDLE, DONE: begin
            if (start_ok) begin
               state_d     = COLLECT;
               done_seen_d = '0;
            end
         end
         COLLECT: begin
            done_seen_d = done_seen_q | in_done;
            if (&done_seen_q) state_d = DRAIN;
         end
         DRAIN: begin
            // A late capture on this edge would strand data in DONE, so wait for it.
            if ((buf_valid_q == '0) && (accept == '0) && !out_valid_q) state_d = DONE;
         end
         default: state_d = IDLE;
      endcase
      if (grant_found) begin
         out_valid_d = 1'b1;
         out_force_d = grant_data;
         out_ch_d    = grant_id;
         rr_ptr_d    = (grant_id == CH_ID_WIDTH'(CHANNEL_NUM - 1)) ? '0 : grant_id + 1'b1;
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         done_seen_q <= '0;
         rr_ptr_q    <= '0;
         out_valid_q <= 1'b0;
         out_force_q <= '0;
         out_ch_q    <= '0;
      end else begin
         state_q     <= state_d;
         done_seen_q <= done_seen_d;
         rr_ptr_q    <= rr_ptr_d;
         out_valid_q <= out_valid_d;
         out_force_q <= out_force_d;
         out_ch_q    <= out_ch_d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         buf_valid_q <= '0;
         for (int c = 0; c < CHANNEL_NUM; c++) buf_data_q[c] <= '0;
      end else begin
         for (int c = 0; c < CHANNEL_NUM; c++) begin
            if (accept[c]) begin
               buf_valid_q[c] <= 1'b1;
               buf_data_q[c]  <= in_force[c*DATA_WIDTH +: DATA_WIDTH];
            end else if (grant_oh[c]) begin
               buf_valid_q[c] <= 1'b0;
            end
         end
      end
   end

`ifdef RL_COLLECTOR_STATS_EN
   logic [COUNT_WIDTH-1:0] result_count_q;
   logic                   drop_err_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         result_count_q <= '0;
         drop_err_q     <= 1'b0;
      end else if (start_ok) begin
         result_count_q <= '0;
         drop_err_q     <= 1'b0;
      end else begin
         if (out_valid_q && out_ready && !(&result_count_q))
            result_count_q <= result_count_q + 1'b1;
         if (!run_active && (|in_valid))
            drop_err_q <= 1'b1;
      end
   end

   assign result_count = result_count_q;
   assign drop_err     = drop_err_q;
`else
   assign result_count = '0;
   assign drop_err     = 1'b0;
`endif

   assign out_valid = out_valid_q;
   assign out_force = out_force_q;
   assign out_ch    = out_ch_q;
   assign busy      = run_active;
   assign done      = (state_q == DONE);

endmodule
`default_nettype wire

// File: tb/tb_rl_force_collector.sv
`default_nettype none
// tb_rl_force_collector: directed vectors with hand-computed expectations for rl_force_collector.
module tb_rl_force_collector;
   localparam int DW  = 32;
   localparam int CH  = 8;
   localparam int IDW = 3;
   localparam int CW  = 16;
`ifdef RL_COLLECTOR_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              start = 1'b0;
   logic [CH*DW-1:0]  in_force = '0;
   logic [CH-1:0]     in_valid = '0;
   logic [CH-1:0]     in_ready;
   logic [CH-1:0]     in_done = '0;
   logic [DW-1:0]     out_force;
   logic [IDW-1:0]    out_ch;
   logic              out_valid;
   logic              out_ready = 1'b1;
   logic              busy;
   logic              done;
   logic [CW-1:0]     result_count;
   logic              drop_err;

   int n_pass  = 0;
   int n_total = 0;

   rl_force_collector #(
      .DATA_WIDTH (DW),
      .CHANNEL_NUM(CH),
      .CH_ID_WIDTH(IDW),
      .COUNT_WIDTH(CW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .in_force    (in_force),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_done     (in_done),
      .out_force   (out_force),
      .out_ch      (out_ch),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .busy        (busy),
      .done        (done),
      .result_count(result_count),
      .drop_err    (drop_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ovalid"}, 64'(out_valid), 64'd0);
      check({tag, "_oforce"}, 64'(out_force), 64'd0);
      check({tag, "_och"}, 64'(out_ch), 64'd0);
      check({tag, "_busy"}, 64'(busy), 64'd0);
      check({tag, "_done"}, 64'(done), 64'd0);
      check({tag, "_rcount"}, 64'(result_count), 64'd0);
      check({tag, "_drop"}, 64'(drop_err), 64'd0);
      check({tag, "_iready"}, 64'(in_ready), 64'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      // Reset state
      step();
      step();
      check_reset_outputs("reset");
      rst = 1'b1;
      step();
      check("idle_busy", 64'(busy), 64'd0);

      // Input while idle is dropped and flagged
      in_valid = 8'b0000_0010;
      in_force[1*DW +: DW] = 32'hDEAD_0001;
      step();
      in_valid = '0;
      check("idle_drop_err", 64'(drop_err), STATS ? 64'd1 : 64'd0);
      check("idle_in_ready", 64'(in_ready), 64'd0);
      check("idle_no_output", 64'(out_valid), 64'd0);

      // Start clears drop_err and opens all channels
      start = 1'b1;
      step();
      start = 1'b0;
      check("start_busy", 64'(busy), 64'd1);
      check("start_drop_clr", 64'(drop_err), 64'd0);
      check("start_in_ready", 64'(in_ready), 64'hFF);
      check("start_rcount", 64'(result_count), 64'd0);

      // Single channel
      in_valid = 8'b0000_0100;
      in_force[2*DW +: DW] = 32'h3F80_0000;
      step();
      in_valid = '0;
      check("single_not_yet", 64'(out_valid), 64'd0);
      step();
      check("single_ovalid", 64'(out_valid), 64'd1);
      check("single_force", 64'(out_force), 64'h3F80_0000);
      check("single_ch", 64'(out_ch), 64'd2);
      check("single_ready_back", 64'(in_ready[2]), 64'd1);
      step();
      check("single_drained", 64'(out_valid), 64'd0);
      check("single_rcount", 64'(result_count), STATS ? 64'd1 : 64'd0);

      // Asynchronous reset mid-run with output held
      out_ready = 1'b0;
      in_valid = 8'b0001_0000;
      in_force[4*DW +: DW] = 32'h4444_4444;
      step();
      in_valid = '0;
      step();
      check("pre_rst_ovalid", 64'(out_valid), 64'd1);
      #2;
      rst = 1'b0;
      #1;
      check_reset_outputs("async_rst");
      step();
      rst = 1'b1;
      out_ready = 1'b1;
      step();
      step();
      check("post_rst_idle", 64'(busy), 64'd0);
      check("post_rst_no_out", 64'(out_valid), 64'd0);

      // Contention: channels 0, 3, 7 together
      start = 1'b1;
      step();
      start = 1'b0;
      in_valid = 8'b1000_1001;
      in_force[0*DW +: DW] = 32'hA000_0000;
      in_force[3*DW +: DW] = 32'hA000_0003;
      in_force[7*DW +: DW] = 32'hA000_0007;
      step();
      in_valid = '0;
      step();
      check("cont_ch_a", 64'(out_ch), 64'd0);
      check("cont_force_a", 64'(out_force), 64'hA000_0000);
      step();
      check("cont_ch_b", 64'(out_ch), 64'd3);
      check("cont_force_b", 64'(out_force), 64'hA000_0003);
      step();
      check("cont_ch_c", 64'(out_ch), 64'd7);
      check("cont_force_c", 64'(out_force), 64'hA000_0007);
      step();
      check("cont_empty", 64'(out_valid), 64'd0);
      // Pointer wrapped to 0: channel 0 beats channel 2
      in_valid = 8'b0000_0101;
      in_force[0*DW +: DW] = 32'hB000_0000;
      in_force[2*DW +: DW] = 32'hB000_0002;
      step();
      in_valid = '0;
      step();
      check("wrap_ch_first", 64'(out_ch), 64'd0);
      step();
      check("wrap_ch_second", 64'(out_ch), 64'd2);
      check("wrap_force_second", 64'(out_force), 64'hB000_0002);
      step();

      // Backpressure: pointer at 3 so channel 5 precedes channel 1
      out_ready = 1'b0;
      in_valid = 8'b0010_0010;
      in_force[1*DW +: DW] = 32'hC000_0001;
      in_force[5*DW +: DW] = 32'hC000_0005;
      step();
      in_valid = '0;
      step();
      for (int k = 0; k < 5; k++) begin
         check("bp_ovalid", 64'(out_valid), 64'd1);
         check("bp_ch", 64'(out_ch), 64'd5);
         check("bp_force", 64'(out_force), 64'hC000_0005);
         check("bp_in_ready", 64'(in_ready), 64'hFD);
         step();
      end
      out_ready = 1'b1;
      step();
      check("bp_release_ch", 64'(out_ch), 64'd1);
      check("bp_release_force", 64'(out_force), 64'hC000_0001);
      step();
      check("bp_drained", 64'(out_valid), 64'd0);
      check("bp_rcount", 64'(result_count), STATS ? 64'd7 : 64'd0);

      // Completion with two results still buffered
      out_ready = 1'b0;
      in_valid = 8'b0101_0000;
      in_force[4*DW +: DW] = 32'hD000_0004;
      in_force[6*DW +: DW] = 32'hD000_0006;
      in_done = 8'hFF;
      step();
      in_valid = '0;
      in_done = '0;
      step();
      check("cmp_busy_a", 64'(busy), 64'd1);
      check("cmp_done_a", 64'(done), 64'd0);
      step();
      check("cmp_busy_drain", 64'(busy), 64'd1);
      check("cmp_hold_ch", 64'(out_ch), 64'd4);
      out_ready = 1'b1;
      step();
      check("cmp_ch_last", 64'(out_ch), 64'd6);
      check("cmp_done_early", 64'(done), 64'd0);
      for (int k = 0; k < 10 && !done; k++) step();
      check("cmp_done", 64'(done), 64'd1);
      check("cmp_busy_off", 64'(busy), 64'd0);
      check("cmp_no_out", 64'(out_valid), 64'd0);
      check("cmp_rcount", 64'(result_count), STATS ? 64'd9 : 64'd0);
      start = 1'b1;
      step();
      start = 1'b0;
      check("restart_done", 64'(done), 64'd0);
      check("restart_busy", 64'(busy), 64'd1);
      check("restart_rcount", 64'(result_count), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
`default_nettype wire
